uart_tx: RTL and testbench

Serial transmitter for the duplex UART link: accepts 7-bit parallel words over a valid/ready handshake and shifts them out on a single line in the exact frame format `uart_rx` decodes. Frame format:

- Line idles low (0).
- Start bit is high (1).
- 7 data bits follow, LSB first.
- An optional parity bit follows the data.
- GAP_BITS low bits close the frame.

A one-word holding buffer lets the next word be accepted during the current frame, so frames can be sent back-to-back.

---
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serial UART transmitter: 7-bit words framed as high start bit, LSB-first data,
// optional parity and GAP_BITS low bits, with a one-word holding buffer for back-to-back frames.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 1,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       data_out,
    output logic       busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int GAP_W  = $clog2(GAP_BITS) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, GAP} state_t;

    state_t            state_reg;
    logic [6:0]        hold_reg;
    logic [6:0]        shift_reg;
    logic              hold_full_reg;
    logic              parity_reg;
    logic              data_out_reg;
    logic              busy_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;

    logic bit_end;
    logic gap_end;
    logic accept;
    logic load;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);
    assign gap_end = (state_reg == GAP) && bit_end && (gap_cnt_reg == GAP_LAST);
    assign accept  = data_valid && !hold_full_reg;
    // A held word starts either from idle or straight out of the final gap cycle.
    assign load    = hold_full_reg && ((state_reg == IDLE) || gap_end);

    assign ready    = ~hold_full_reg;
    assign data_out = data_out_reg;
    assign busy     = busy_reg;

    // Payload registers carry no reset: their contents are only used after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_reg <= data_in;
        end
        if (load) begin
            shift_reg  <= hold_reg;
            parity_reg <= (^hold_reg) ^ PARITY_ODD;
        end else if ((state_reg == DATA) && bit_end) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            hold_full_reg <= 1'b0;
            data_out_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            gap_cnt_reg   <= '0;
        end else begin
            if (load) begin
                hold_full_reg <= 1'b0;
            end else if (accept) begin
                hold_full_reg <= 1'b1;
            end

            if ((state_reg == IDLE) || bit_end) begin
                baud_cnt_reg <= '0;
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end

            // data_out/busy are registered, so each transition drives the next bit's level.
            case (state_reg)
                IDLE: begin
                    data_out_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    if (load) begin
                        state_reg    <= START;
                        data_out_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg    <= DATA;
                        bit_idx_reg  <= '0;
                        data_out_reg <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == 3'd6) begin
                            gap_cnt_reg <= '0;
                            if (PARITY_EN) begin
                                state_reg    <= PARITY;
                                data_out_reg <= parity_reg;
                            end else begin
                                state_reg    <= GAP;
                                data_out_reg <= 1'b0;
                            end
                        end else begin
                            bit_idx_reg  <= bit_idx_reg + 3'd1;
                            data_out_reg <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_reg    <= GAP;
                        gap_cnt_reg  <= '0;
                        data_out_reg <= 1'b0;
                    end
                end
                GAP: begin
                    if (bit_end) begin
                        if (gap_cnt_reg == GAP_LAST) begin
                            gap_cnt_reg <= '0;
                            if (load) begin
                                state_reg    <= START;
                                data_out_reg <= 1'b1;
                            end else begin
                                state_reg    <= IDLE;
                                data_out_reg <= 1'b0;
                                busy_reg     <= 1'b0;
                            end
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    data_out_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame/reset checks on a default instance plus
// randomized scoreboard traffic on three parameter sets.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int NCFG = 3;

    typedef struct {
        logic [6:0] word;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;
    int n_done = 0;

    task automatic fail(input string msg);
        errors++;
        if (errors <= 40) $display("FAIL %s", msg);
    endtask

    // Directed instance with default parameters.
    logic       d_rst_n = 1'b0;
    logic       d_valid = 1'b0;
    logic [6:0] d_data  = '0;
    logic       d_ready;
    logic       d_out;
    logic       d_busy;
    logic       exp5a [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    uart_tx u_dir (
        .clk        (clk),
        .rst_n      (d_rst_n),
        .data_in    (d_data),
        .data_valid (d_valid),
        .ready      (d_ready),
        .data_out   (d_out),
        .busy       (d_busy)
    );

    initial begin : directed
        #1;
        checks++;
        if (d_out !== 1'b0 || d_busy !== 1'b0 || d_ready !== 1'b1)
            fail($sformatf("reset_state: out=%b busy=%b ready=%b, want 0 0 1", d_out, d_busy, d_ready));
        repeat (2) @(negedge clk);
        d_rst_n = 1'b1;
        @(negedge clk);
        d_data  = 7'h5A;
        d_valid = 1'b1;
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0 || d_busy !== 1'b0 || d_out !== 1'b0)
            fail($sformatf("accept_cycle: ready=%b busy=%b out=%b, want 0 0 0", d_ready, d_busy, d_out));
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (d_out !== exp5a[k] || d_busy !== 1'b1 || d_ready !== 1'b1)
                fail($sformatf("frame_5a bit %0d: out=%b busy=%b ready=%b, want %b 1 1",
                               k, d_out, d_busy, d_ready, exp5a[k]));
        end
        @(negedge clk);
        checks++;
        if (d_busy !== 1'b0 || d_out !== 1'b0)
            fail($sformatf("frame_5a end: busy=%b out=%b, want 0 0", d_busy, d_out));
        $display("directed: frame 5a checked");

        // Reset mid-DATA with a second word held.
        @(negedge clk);
        d_data  = 7'h7F;
        d_valid = 1'b1;
        @(posedge clk);
        #1 d_data = 7'h4C;
        @(posedge clk);
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (d_busy !== 1'b1 || d_out !== 1'b1 || d_ready !== 1'b0)
            fail($sformatf("pre_reset: busy=%b out=%b ready=%b, want 1 1 0", d_busy, d_out, d_ready));
        d_rst_n = 1'b0;
        #1;
        checks++;
        if (d_out !== 1'b0 || d_busy !== 1'b0 || d_ready !== 1'b1)
            fail($sformatf("async_reset: out=%b busy=%b ready=%b, want 0 0 1", d_out, d_busy, d_ready));
        @(negedge clk);
        d_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (d_out !== 1'b0 || d_busy !== 1'b0)
                fail($sformatf("post_reset_idle cycle %0d: out=%b busy=%b, want 0 0", k, d_out, d_busy));
        end
        $display("directed: mid-frame reset checked");
        n_done++;
    end

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int C  = (gi == 0) ? 1 : 4;
        localparam int G  = (gi == 2) ? 3 : 1;
        localparam bit PE = (gi != 0);
        localparam bit PO = (gi == 2);
        localparam int NB = 8 + int'(PE) + G;
        localparam int L  = NB * C;
        localparam int NW = (gi == 0) ? 128 : 30;

        logic       rst_n      = 1'b0;
        logic       data_valid = 1'b0;
        logic [6:0] data_in    = '0;
        logic       ready;
        logic       data_out;
        logic       busy;

        exp_t q[$];
        bit   mon_en    = 1'b0;
        int   prev_end  = 0;
        int   last_load = 0;

        uart_tx #(
            .CLKS_PER_BIT (C),
            .GAP_BITS     (G),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .data_in    (data_in),
            .data_valid (data_valid),
            .ready      (ready),
            .data_out   (data_out),
            .busy       (busy)
        );

        // Reference frame: slot 0 start, slots 1..7 data LSB first, then parity, then gap.
        function automatic logic exp_bit(input logic [6:0] w, input int b);
            if (b == 0) return 1'b1;
            if (b <= 7) return w[b-1];
            if (PE && b == 8) return (($countones(w) % 2) != 0) ^ PO;
            return 1'b0;
        endfunction

        function automatic logic [6:0] word_of(input int i);
            if (gi == 0) return 7'(i);
            if (i == 0) return 7'h07;
            if (i <= 2) return 7'h7F;
            return 7'($urandom);
        endfunction

        task automatic send_word(input logic [6:0] w, input int idle);
            int   a;
            int   ld;
            bit   accepted;
            exp_t e;
            if (idle > 0) begin
                data_valid = 1'b0;
                repeat (idle) @(posedge clk);
                #1;
            end
            data_valid = 1'b1;
            data_in    = w;
            accepted   = 1'b0;
            for (int n = 0; n < 2 * L + 8 && !accepted; n++) begin
                @(negedge clk);
                checks++;
                if (ready !== (edge_cnt >= last_load))
                    fail($sformatf("ready_cfg%0d edge %0d: ready=%b, want %b",
                                   gi, edge_cnt, ready, (edge_cnt >= last_load)));
                if (ready === 1'b1) begin
                    a  = edge_cnt + 1;
                    ld = (a + 1 > prev_end) ? a + 1 : prev_end;
                    e.word  = w;
                    e.start = ld;
                    q.push_back(e);
                    last_load = ld;
                    prev_end  = ld + L;
                    accepted  = 1'b1;
                end
                @(posedge clk);
                #1;
            end
            if (!accepted) begin
                checks++;
                fail($sformatf("stall_cfg%0d: word %02h never accepted, want accepted", gi, w));
                data_valid = 1'b0;
            end
        endtask

        initial begin : driver
            int idle;
            repeat (3) @(negedge clk);
            rst_n  = 1'b1;
            mon_en = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < NW; i++) begin
                if (gi == 0 || i < 3) idle = 0;
                else idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, L + 3)) : 0;
                send_word(word_of(i), idle);
            end
            data_valid = 1'b0;
            while (edge_cnt < prev_end + 2) @(negedge clk);
            checks++;
            if (q.size() != 0)
                fail($sformatf("leftover_cfg%0d: %0d frames not seen, want 0", gi, q.size()));
            n_done++;
        end

        initial begin : monitor
            exp_t       e;
            bit         ok;
            logic [6:0] got;
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (q.size() > 0 && edge_cnt == q[0].start) begin
                        e   = q.pop_front();
                        ok  = 1'b1;
                        got = '0;
                        for (int b = 0; b < NB; b++) begin
                            for (int c = 0; c < C; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (data_out !== exp_bit(e.word, b) || busy !== 1'b1) ok = 1'b0;
                                if (c == 0 && b >= 1 && b <= 7) got[b-1] = data_out;
                            end
                        end
                        checks++;
                        if (!ok)
                            fail($sformatf("frame_cfg%0d from edge %0d: got data %02h (or bad framing/busy), want %02h",
                                           gi, e.start, got, e.word));
                        else
                            $display("cfg%0d: frame %02h from edge %0d", gi, e.word, e.start);
                    end else begin
                        checks++;
                        if (data_out !== 1'b0 || busy !== 1'b0)
                            fail($sformatf("idle_cfg%0d edge %0d: out=%b busy=%b, want 0 0",
                                           gi, edge_cnt, data_out, busy));
                    end
                end
            end
        end
    end

    initial begin : main
        for (int t = 0; t < 40000 && n_done < NCFG + 1; t++) @(negedge clk);
        if (n_done < NCFG + 1) begin
            checks++;
            fail($sformatf("timeout: %0d of %0d streams finished", n_done, NCFG + 1));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
